// File: rtl/mem_test_master.sv
// Memory write/read-back tester: writes addr^seed over a region, reads it back and counts mismatches.
// Read data is compared one cycle after each read strobe; the final read is compared in CHECK.
module mem_test_master #(
  parameter int          N_WORDS   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        wr_en,
  output logic        rd_en,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [31:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

  localparam logic [15:0] LAST = 16'(N_WORDS);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] seed_q, seed_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] first_err_addr_q, first_err_addr_d;
  logic        chk_vld_q, chk_vld_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] exp_addr_q, exp_addr_d;
  logic        mismatch;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    seed_d           = seed_q;
    wr_en_d          = 1'b0;
    rd_en_d          = 1'b0;
    addr_d           = 32'h0;
    wdata_d          = 32'h0;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    // One-stage pipeline: the read issued this cycle is checked when its data returns.
    chk_vld_d        = (state_q == READ);
    exp_d            = addr_q ^ seed_q;
    exp_addr_d       = addr_q;

    mismatch = chk_vld_q && (rdata != exp_q);
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'h0)    first_err_addr_d = exp_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d          = WRITE;
          seed_d           = seed;
          err_cnt_d        = 16'h0;
          first_err_addr_d = 32'h0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
          wr_en_d          = 1'b1;
          addr_d           = BASE_ADDR;
          wdata_d          = BASE_ADDR ^ seed;
          cnt_d            = 16'd1;
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          state_d = READ;
          rd_en_d = 1'b1;
          addr_d  = BASE_ADDR;
          cnt_d   = 16'd1;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = addr_q + 32'd1;
          wdata_d = (addr_q + 32'd1) ^ seed_q;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          state_d = CHECK;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_cnt_d == 16'h0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 16'h0;
      seed_q           <= 32'h0;
      wr_en_q          <= 1'b0;
      rd_en_q          <= 1'b0;
      addr_q           <= 32'h0;
      wdata_q          <= 32'h0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= 16'h0;
      first_err_addr_q <= 32'h0;
      chk_vld_q        <= 1'b0;
      exp_q            <= 32'h0;
      exp_addr_q       <= 32'h0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      seed_q           <= seed_d;
      wr_en_q          <= wr_en_d;
      rd_en_q          <= rd_en_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      chk_vld_q        <= chk_vld_d;
      exp_q            <= exp_d;
      exp_addr_q       <= exp_addr_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign rd_en          = rd_en_q;
  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: two instances (plain region and one wrapping past 2^32)
// share stimulus; each has its own registered memory model with selectable corruption.
module tb_mem_test_master;

  localparam logic [31:0] BASE0 = 32'd16;
  localparam logic [31:0] BASE1 = 32'hFFFFFFFE;
  localparam int          NW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        wr_en [2];
  logic        rd_en [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] first_err_addr [2];
  logic [15:0] err_cnt [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] corrupt = 16'h0;
  logic [31:0] mem [2][16];
  logic        clr = 1'b0;

  logic [31:0] w_addr [2][16];
  logic [31:0] w_data [2][16];
  logic [31:0] r_addr [2][16];
  int wn [2], rn [2], done_n [2], busy_n [2], overlap [2], rd_wbad [2], idle_bad [2], done_cyc [2];

  mem_test_master #(.N_WORDS(NW), .BASE_ADDR(BASE0)) u_a (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .first_err_addr(first_err_addr[0]));

  mem_test_master #(.N_WORDS(NW), .BASE_ADDR(BASE1)) u_b (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .first_err_addr(first_err_addr[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  function automatic logic [3:0] offs(input int k);
    logic [31:0] d;
    d = addr[k] - base_of(k);
    return d[3:0];
  endfunction

  // Registered memory: read data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) mem[k][offs(k)] <= wdata[k];
      if (rd_en[k]) rdata[k] <= corrupt[offs(k)] ? 32'hDEAD : mem[k][offs(k)];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        wn[k] = 0; rn[k] = 0; done_n[k] = 0; busy_n[k] = 0;
        overlap[k] = 0; rd_wbad[k] = 0; idle_bad[k] = 0; done_cyc[k] = 0;
      end else if (!rst) begin
        if (wr_en[k]) begin
          w_addr[k][wn[k] & 15] = addr[k];
          w_data[k][wn[k] & 15] = wdata[k];
          wn[k]++;
        end
        if (rd_en[k]) begin
          r_addr[k][rn[k] & 15] = addr[k];
          if (wdata[k] != 32'h0) rd_wbad[k]++;
          rn[k]++;
        end
        if (wr_en[k] && rd_en[k]) overlap[k]++;
        if (done[k]) begin done_n[k]++; done_cyc[k] = cyc; end
        if (busy[k]) busy_n[k]++;
        if (!busy[k] && (wr_en[k] || rd_en[k] || addr[k] != 32'h0 || wdata[k] != 32'h0)) idle_bad[k]++;
      end
    end
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic launch(input logic [31:0] s, output int acc);
    @(negedge clk);
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_n[0] < n && t < 80) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (done_n[0] < n) begin
      errors++;
      $display("FAIL done_timeout: saw %0d done pulses, need %0d", done_n[0], n);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({wr_en[k], rd_en[k], busy[k], done[k], pass[k], addr[k], wdata[k], err_cnt[k], first_err_addr[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: wr=%b rd=%b busy=%b done=%b pass=%b addr=%h wdata=%h err=%h first=%h, all must be 0",
                 k, wr_en[k], rd_en[k], busy[k], done[k], pass[k], addr[k], wdata[k], err_cnt[k], first_err_addr[k]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_pattern(input logic [31:0] s, input logic [15:0] mask);
    int acc, e_err;
    logic [31:0] b, a, e_first;
    clear_mon();
    corrupt = mask;
    launch(s, acc);
    wait_done(1);
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      b = base_of(k);
      e_err = 0;
      e_first = 32'h0;
      for (int i = 0; i < NW; i++) begin
        a = b + 32'(i);
        if (mask[i] && ((a ^ s) != 32'hDEAD)) begin
          if (e_err == 0) e_first = a;
          e_err++;
        end
      end
      checks++;
      if (wn[k] != NW || rn[k] != NW) begin
        errors++;
        $display("FAIL strobe_count[%0d] seed=%h: writes=%0d reads=%0d, need %0d each", k, s, wn[k], rn[k], NW);
      end
      for (int i = 0; i < NW; i++) begin
        a = b + 32'(i);
        checks++;
        if (w_addr[k][i] !== a || w_data[k][i] !== (a ^ s) || r_addr[k][i] !== a) begin
          errors++;
          $display("FAIL access[%0d][%0d] seed=%h: wr %h/%h rd %h, need wr %h/%h rd %h",
                   k, i, s, w_addr[k][i], w_data[k][i], r_addr[k][i], a, a ^ s, a);
        end
      end
      checks++;
      if (done_n[k] != 1 || done_cyc[k] - acc != 2 * NW + 1 || busy_n[k] != 2 * NW + 1) begin
        errors++;
        $display("FAIL timing[%0d]: done_n=%0d done_lat=%0d busy_cycles=%0d, need 1/%0d/%0d",
                 k, done_n[k], done_cyc[k] - acc, busy_n[k], 2 * NW + 1, 2 * NW + 1);
      end
      checks++;
      if (overlap[k] != 0 || rd_wbad[k] != 0 || idle_bad[k] != 0) begin
        errors++;
        $display("FAIL strobe_rules[%0d]: overlap=%0d rd_wdata_nonzero=%0d idle_nonzero=%0d, need 0",
                 k, overlap[k], rd_wbad[k], idle_bad[k]);
      end
      checks++;
      if (err_cnt[k] !== 16'(e_err) || first_err_addr[k] !== e_first || pass[k] !== (e_err == 0)) begin
        errors++;
        $display("FAIL result[%0d] seed=%h mask=%h: err=%0d first=%h pass=%b, need err=%0d first=%h pass=%b",
                 k, s, mask, err_cnt[k], first_err_addr[k], pass[k], e_err, e_first, e_err == 0);
      end
    end
  endtask

  task automatic test_start_ignored();
    int acc;
    clear_mon();
    corrupt = 16'h0;
    launch(32'h0BAD_F00D, acc);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1);
    repeat (20) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done_n[k] != 1 || done_cyc[k] - acc != 2 * NW + 1 || busy_n[k] != 2 * NW + 1 ||
          wn[k] != NW || rn[k] != NW || pass[k] !== 1'b1) begin
        errors++;
        $display("FAIL start_ignored[%0d]: done_n=%0d lat=%0d busy=%0d wr=%0d rd=%0d pass=%b, need 1/%0d/%0d/%0d/%0d/1",
                 k, done_n[k], done_cyc[k] - acc, busy_n[k], wn[k], rn[k], pass[k], 2 * NW + 1, 2 * NW + 1, NW, NW);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_mon();
    corrupt = 16'h0;
    launch(32'h5A5A_5A5A, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({wr_en[k], rd_en[k], busy[k], done[k], pass[k], addr[k], wdata[k], err_cnt[k], first_err_addr[k]} !== '0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: wr=%b rd=%b busy=%b done=%b addr=%h wdata=%h, all must be 0",
                 k, wr_en[k], rd_en[k], busy[k], done[k], addr[k], wdata[k]);
      end
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done_n[k] != 0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort[%0d]: done_n=%0d busy=%b, need 0/0", k, done_n[k], busy[k]);
      end
    end
    test_pattern(32'h0, 16'h0);
  endtask

  task automatic test_back_to_back(input logic [31:0] s);
    int t, d;
    clear_mon();
    corrupt = 16'h0;
    @(negedge clk);
    seed = s;
    start = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!done[0] && t < 60);
    checks++;
    if (!done[0]) begin
      errors++;
      $display("FAIL b2b_first_done: no done within %0d cycles", t);
    end
    d = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (wr_en[k] !== 1'b1 || addr[k] !== base_of(k) || busy[k] !== 1'b1 || pass[k] !== 1'b0 || done[k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_restart[%0d]: wr=%b addr=%h busy=%b pass=%b done=%b, need 1/%h/1/0/0",
                 k, wr_en[k], addr[k], busy[k], pass[k], done[k], base_of(k));
      end
    end
    wait_done(2);
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done_n[k] != 2 || done_cyc[k] != d + 2 * NW + 2 || wn[k] != 2 * NW || pass[k] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_second[%0d]: done_n=%0d done_cyc=%0d wr=%0d pass=%b, need 2/%0d/%0d/1",
                 k, done_n[k], done_cyc[k], wn[k], pass[k], d + 2 * NW + 2, 2 * NW);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern(32'h0000_1000, 16'h0000);
    test_pattern(32'h0000_1000, 16'h0004);
    test_pattern(32'h0000_1000, 16'h000A);
    for (int r = 0; r < 5; r++) test_pattern($urandom, 16'($urandom_range(0, 15)));
    test_start_ignored();
    test_reset_mid();
    test_back_to_back(32'hCAFE_0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
